// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   state_e      : FSM state encoding (IDLE -> ACCESS -> RESP)
//   REQ_A/REQ_B  : requester ids carried through grant and response logic
//   DEF_DW/AW    : default data/address widths (8x8 memory)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst    : clock, synchronous active-high reset (ptr returns to A)
//   req_i[1:0]  : request vector, bit 0 = A, bit 1 = B
//   advance_i   : flip the priority pointer (pulsed once per completed transaction)
//   gnt_id_o    : winning requester id (combinational)
//   gnt_vld_o   : at least one request is present
//   ptr_o       : current priority side
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       gnt_id_o,
  output logic       gnt_vld_o,
  output logic       ptr_o
);

  logic ptr_q, ptr_d;

  // Advance unconditionally: a rejected access still uses up the winner's turn.
  assign ptr_d = advance_i ? ~ptr_q : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= REQ_A;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_id_o = REQ_A;
    unique case (req_i)
      2'b01:   gnt_id_o = REQ_A;
      2'b10:   gnt_id_o = REQ_B;
      2'b11:   gnt_id_o = ptr_q;
      default: gnt_id_o = REQ_A;
    endcase
  end

  assign gnt_vld_o = |req_i;
  assign ptr_o     = ptr_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between requesters A and B.
// Each transaction: IDLE (arbitrate, check flags) -> ACCESS (one strobe cycle)
// -> RESP (done/err/rdata to the winner). Rejected accesses skip ACCESS.
//   clk, rst                    : clock, synchronous active-high reset
//   a_/b_req, we, addr, wdata   : requester inputs, held stable until done
//   a_/b_done, err, rdata       : registered responses to each requester
//   mem_en_w, mem_en_r          : registered one-cycle memory strobes
//   mem_address, mem_data_in    : registered memory address / write data
//   mem_data_out                : read data, valid the cycle after mem_en_r
//   mem_full_flag/empty_flag    : sampled only in the IDLE decision cycle
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_done,
  output logic          a_err,
  output logic [DW-1:0] a_rdata,
  output logic          b_done,
  output logic          b_err,
  output logic [DW-1:0] b_rdata,
  output logic          mem_en_w,
  output logic          mem_en_r,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_data_in,
  input  logic [DW-1:0] mem_data_out,
  input  logic          mem_full_flag,
  input  logic          mem_empty_flag
);

  state_e        state_q;
  logic          win_q, we_q, rej_q;
  logic          a_done_q, a_err_q, b_done_q, b_err_q;
  logic [DW-1:0] a_rdata_q, b_rdata_q;
  logic          mem_en_w_q, mem_en_r_q;
  logic [AW-1:0] mem_address_q;
  logic [DW-1:0] mem_data_in_q;

  logic          gnt_id, gnt_vld, ptr;
  logic          sel_we, reject;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     ({b_req, a_req}),
    .advance_i (state_q == RESP),
    .gnt_id_o  (gnt_id),
    .gnt_vld_o (gnt_vld),
    .ptr_o     (ptr)
  );

  // Winner's request fields, only meaningful in IDLE with gnt_vld.
  assign sel_we    = (gnt_id == REQ_B) ? b_we    : a_we;
  assign sel_addr  = (gnt_id == REQ_B) ? b_addr  : a_addr;
  assign sel_wdata = (gnt_id == REQ_B) ? b_wdata : a_wdata;
  assign reject    = sel_we ? mem_full_flag : mem_empty_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      win_q         <= REQ_A;
      we_q          <= 1'b0;
      rej_q         <= 1'b0;
      a_done_q      <= 1'b0;
      a_err_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_done_q      <= 1'b0;
      b_err_q       <= 1'b0;
      b_rdata_q     <= '0;
      mem_en_w_q    <= 1'b0;
      mem_en_r_q    <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
    end else begin
      // Pulses default low; address/data simply hold between accesses.
      a_done_q   <= 1'b0;
      b_done_q   <= 1'b0;
      mem_en_w_q <= 1'b0;
      mem_en_r_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            win_q <= gnt_id;
            we_q  <= sel_we;
            rej_q <= reject;
            if (reject) begin
              state_q <= RESP;
            end else begin
              // Strobe is registered here so it is visible exactly during ACCESS.
              mem_en_w_q    <= sel_we;
              mem_en_r_q    <= ~sel_we;
              mem_address_q <= sel_addr;
              mem_data_in_q <= sel_wdata;
              state_q       <= ACCESS;
            end
          end
        end
        ACCESS: state_q <= RESP;
        RESP: begin
          // mem_data_out carries the read result during RESP (one cycle after en_r).
          if (win_q == REQ_A) begin
            a_done_q <= 1'b1;
            a_err_q  <= rej_q;
            if (!rej_q && !we_q) a_rdata_q <= mem_data_out;
          end else begin
            b_done_q <= 1'b1;
            b_err_q  <= rej_q;
            if (!rej_q && !we_q) b_rdata_q <= mem_data_out;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_done      = a_done_q;
  assign a_err       = a_err_q;
  assign a_rdata     = a_rdata_q;
  assign b_done      = b_done_q;
  assign b_err       = b_err_q;
  assign b_rdata     = b_rdata_q;
  assign mem_en_w    = mem_en_w_q;
  assign mem_en_r    = mem_en_r_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;

  // Pointer is observed only through grant order.
  logic unused_ptr;
  assign unused_ptr = ptr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 8x8 memory attached.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [2:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wdata = 0, b_wdata = 0;
  logic       a_done, a_err, b_done, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_en_w, mem_en_r;
  logic [2:0] mem_address;
  logic [7:0] mem_data_in, mem_data_out;
  logic       mem_full_flag = 0, mem_empty_flag = 0;

  logic [7:0] tb_mem [0:7];
  int         wr_cnt = 0, rd_cnt = 0;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_en_w(mem_en_w), .mem_en_r(mem_en_r),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out),
    .mem_full_flag(mem_full_flag), .mem_empty_flag(mem_empty_flag)
  );

  // Memory model: synchronous write, read data one cycle after en_r.
  always @(posedge clk) begin
    if (mem_en_w) begin tb_mem[mem_address] <= mem_data_in; wr_cnt <= wr_cnt + 1; end
    if (mem_en_r) begin mem_data_out <= tb_mem[mem_address]; rd_cnt <= rd_cnt + 1; end
  end

  // One clock; returns on the falling edge where outputs are stable.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    a_req = 1; a_we = 1; a_addr = 7; a_wdata = 8'h0A;
    b_req = 1; b_we = 1; b_addr = 6; b_wdata = 8'h0B;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({a_done, b_done, a_err, b_err, a_rdata, b_rdata, mem_en_w, mem_en_r, mem_address, mem_data_in} !== 36'h0) begin
        errors++; $display("FAIL reset_outputs cyc%0d: got %h required 0", i,
          {a_done, b_done, a_err, b_err, a_rdata, b_rdata, mem_en_w, mem_en_r, mem_address, mem_data_in});
      end
    end
    rst = 0;
    tick();
    checks++;
    if ({mem_en_w, mem_en_r, mem_address, mem_data_in} !== {2'b10, 3'd7, 8'h0A}) begin
      errors++; $display("FAIL reset_first_grant: got w%b r%b a%0d d%h required A (w1 r0 a7 d0a)",
        mem_en_w, mem_en_r, mem_address, mem_data_in);
    end
    tick(); tick();
    checks++;
    if ({a_done, b_done, a_err} !== 3'b100) begin
      errors++; $display("FAIL reset_a_done: got a%b b%b err%b required 1 0 0", a_done, b_done, a_err);
    end
    a_req = 0;
    tick();
    checks++;
    if ({mem_en_w, mem_address, mem_data_in} !== {1'b1, 3'd6, 8'h0B}) begin
      errors++; $display("FAIL reset_b_next: got w%b a%0d d%h required w1 a6 d0b", mem_en_w, mem_address, mem_data_in);
    end
    tick(); tick();
    checks++;
    if ({a_done, b_done, b_err} !== 3'b010) begin
      errors++; $display("FAIL reset_b_done: got a%b b%b err%b required 0 1 0", a_done, b_done, b_err);
    end
    b_req = 0;
    tick();
  endtask

  task automatic test_single_write_read();
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = 8'h5A;
    tick();
    checks++;
    if ({mem_en_w, mem_en_r, mem_address, mem_data_in, a_done} !== {2'b10, 3'd3, 8'h5A, 1'b0}) begin
      errors++; $display("FAIL wr_strobe: got w%b r%b a%0d d%h done%b required w1 r0 a3 d5a done0",
        mem_en_w, mem_en_r, mem_address, mem_data_in, a_done);
    end
    tick();
    checks++;
    if ({mem_en_w, mem_en_r, a_done} !== 3'b000) begin
      errors++; $display("FAIL wr_resp_cycle: got w%b r%b done%b required 0 0 0", mem_en_w, mem_en_r, a_done);
    end
    tick();
    checks++;
    if ({a_done, a_err, b_done} !== 3'b100 || tb_mem[3] !== 8'h5A) begin
      errors++; $display("FAIL wr_done: got done%b err%b bdone%b mem%h required 1 0 0 5a", a_done, a_err, b_done, tb_mem[3]);
    end
    a_req = 0;
    tick();
    a_req = 1; a_we = 0; a_addr = 3; a_wdata = 8'h00;
    tick();
    checks++;
    if ({mem_en_w, mem_en_r, mem_address} !== {2'b01, 3'd3}) begin
      errors++; $display("FAIL rd_strobe: got w%b r%b a%0d required w0 r1 a3", mem_en_w, mem_en_r, mem_address);
    end
    tick(); tick();
    checks++;
    if ({a_done, a_err, a_rdata} !== {2'b10, 8'h5A}) begin
      errors++; $display("FAIL rd_done: got done%b err%b rdata%h required 1 0 5a", a_done, a_err, a_rdata);
    end
    a_req = 0;
    tick();
    checks++;
    if ({a_done, a_rdata} !== {1'b0, 8'h5A}) begin
      errors++; $display("FAIL rd_hold: got done%b rdata%h required 0 5a", a_done, a_rdata);
    end
  endtask

  task automatic test_contention();
    // Expected per cycle 1..9: strobe on 1,4,7 (A,B,A); a_done 3,9; b_done 6.
    logic [9:1] exp_en, exp_ad, exp_bd;
    logic [2:0] exp_addr [1:9];
    exp_en = 9'b001001001; exp_ad = 9'b100000100; exp_bd = 9'b000100000;
    exp_addr = '{3'd1, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    a_req = 1; a_we = 1; a_addr = 1; a_wdata = 8'h11;
    b_req = 1; b_we = 1; b_addr = 2; b_wdata = 8'h22;
    for (int i = 1; i <= 9; i++) begin
      tick();
      checks++;
      if (mem_en_r !== 1'b0 || mem_en_w !== exp_en[i] || (exp_en[i] && mem_address !== exp_addr[i])) begin
        errors++; $display("FAIL cont_strobe cyc%0d: got w%b r%b a%0d required w%b r0 a%0d",
          i, mem_en_w, mem_en_r, mem_address, exp_en[i], exp_addr[i]);
      end
      checks++;
      if ({a_done, b_done} !== {exp_ad[i], exp_bd[i]}) begin
        errors++; $display("FAIL cont_done cyc%0d: got a%b b%b required a%b b%b", i, a_done, b_done, exp_ad[i], exp_bd[i]);
      end
    end
    a_req = 0; b_req = 0;
    tick();
    checks++;
    if (tb_mem[1] !== 8'h11 || tb_mem[2] !== 8'h22) begin
      errors++; $display("FAIL cont_mem: got %h %h required 11 22", tb_mem[1], tb_mem[2]);
    end
  endtask

  task automatic test_full_reject();
    int wr0;
    for (int i = 0; i < 8; i++) begin
      a_req = 1; a_we = 1; a_addr = 3'(i); a_wdata = 8'h80 + 8'(i);
      tick(); tick(); tick();
      checks++;
      if ({a_done, a_err} !== 2'b10) begin
        errors++; $display("FAIL fill_done%0d: got done%b err%b required 1 0", i, a_done, a_err);
      end
      a_req = 0;
      tick();
    end
    mem_full_flag = 1;
    wr0 = wr_cnt;
    b_req = 1; b_we = 1; b_addr = 0; b_wdata = 8'hFF;
    tick();
    checks++;
    if ({mem_en_w, b_done} !== 2'b00) begin
      errors++; $display("FAIL full_cyc1: got w%b done%b required 0 0", mem_en_w, b_done);
    end
    tick();
    checks++;
    if ({b_done, b_err, a_done} !== 3'b110) begin
      errors++; $display("FAIL full_reject: got done%b err%b adone%b required 1 1 0", b_done, b_err, a_done);
    end
    b_req = 0;
    tick();
    checks++;
    if (wr_cnt !== wr0 || tb_mem[0] !== 8'h80) begin
      errors++; $display("FAIL full_unchanged: got writes+%0d mem0=%h required +0 80", wr_cnt - wr0, tb_mem[0]);
    end
    // Flag rising after the decision cycle must not affect an accepted write.
    mem_full_flag = 0;
    a_req = 1; a_we = 1; a_addr = 4; a_wdata = 8'h44;
    tick();
    mem_full_flag = 1;
    tick(); tick();
    checks++;
    if ({a_done, a_err} !== 2'b10 || tb_mem[4] !== 8'h44) begin
      errors++; $display("FAIL full_late_flag: got done%b err%b mem4=%h required 1 0 44", a_done, a_err, tb_mem[4]);
    end
    a_req = 0; mem_full_flag = 0;
    tick();
  endtask

  task automatic test_empty_reject();
    int rd0;
    rst = 1; tick(); rst = 0;
    mem_empty_flag = 1;
    rd0 = rd_cnt;
    a_req = 1; a_we = 0; a_addr = 5;
    tick();
    checks++;
    if ({mem_en_r, a_done} !== 2'b00) begin
      errors++; $display("FAIL empty_cyc1: got r%b done%b required 0 0", mem_en_r, a_done);
    end
    tick();
    checks++;
    if ({a_done, a_err, a_rdata} !== {2'b11, 8'h00}) begin
      errors++; $display("FAIL empty_reject: got done%b err%b rdata%h required 1 1 00", a_done, a_err, a_rdata);
    end
    a_req = 0; mem_empty_flag = 0;
    tick();
    checks++;
    if (rd_cnt !== rd0) begin
      errors++; $display("FAIL empty_no_read: got reads+%0d required +0", rd_cnt - rd0);
    end
  endtask

  task automatic test_reset_midop();
    // Pointer now favours B (A's rejected read flipped it).
    a_req = 1; a_we = 1; a_addr = 2; a_wdata = 8'h77;
    tick();
    checks++;
    if (mem_en_w !== 1'b1) begin
      errors++; $display("FAIL midop_access: got w%b required 1", mem_en_w);
    end
    rst = 1; a_req = 0;
    tick();
    checks++;
    if ({mem_en_w, mem_en_r, a_done} !== 3'b000) begin
      errors++; $display("FAIL midop_abort: got w%b r%b done%b required 0 0 0", mem_en_w, mem_en_r, a_done);
    end
    tick();
    rst = 0;
    a_req = 1; a_we = 1; a_addr = 2; a_wdata = 8'h77;
    b_req = 1; b_we = 1; b_addr = 3; b_wdata = 8'h33;
    checks++;
    if (a_done !== 1'b0) begin
      errors++; $display("FAIL midop_no_done: got %b required 0", a_done);
    end
    tick();
    checks++;
    if ({mem_en_w, mem_address, mem_data_in} !== {1'b1, 3'd2, 8'h77}) begin
      errors++; $display("FAIL midop_ptr_a: got w%b a%0d d%h required w1 a2 d77", mem_en_w, mem_address, mem_data_in);
    end
    tick(); tick();
    checks++;
    if ({a_done, b_done} !== 2'b10) begin
      errors++; $display("FAIL midop_a_done: got a%b b%b required 1 0", a_done, b_done);
    end
    a_req = 0;
    tick(); tick(); tick();
    checks++;
    if ({a_done, b_done, b_err} !== 3'b010 || tb_mem[3] !== 8'h33) begin
      errors++; $display("FAIL midop_b_done: got a%b b%b err%b mem3=%h required 0 1 0 33", a_done, b_done, b_err, tb_mem[3]);
    end
    b_req = 0;
    tick();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_write_read();
    test_contention();
    test_full_reject();
    test_empty_reject();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
